// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - iterative RV32I shift execution unit (SLL/SRL/SRA)
//
// Shifts the operand one bit per clock (or four bits per clock while the
// remaining count is at least four when SHIFT_UNIT_FAST_EN is defined) and
// hands the result and a register-file write enable to writeback.
//
// Optional feature macro: SHIFT_UNIT_FAST_EN (4-bit steps while count >= 4).
//
// Ports:
//   clk        in   1     system clock, rising edge
//   reset_n    in   1     asynchronous active-low reset
//   start_i    in   1     request, sampled only in IDLE
//   op_i       in   2     00 SLL, 01 SRL, 11 SRA, 10 reserved (pass-through)
//   operand_i  in   XLEN  rs1 value
//   shamt_i    in   5     shift amount
//   rd_i       in   5     destination register index
//   busy_o     out  1     unit occupied, starts ignored
//   done_o     out  1     one-cycle completion pulse
//   result_o   out  XLEN  shifted value, held until the next completion
//   rd_o       out  5     destination index aligned with result_o
//   we_o       out  1     regfile write enable (done_o and rd_o != 0)

module shift_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic [4:0]      shamt_i,
    input  logic [4:0]      rd_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            we_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t          state;
    logic [XLEN-1:0] work;
    logic [4:0]      count;
    logic [1:0]      op_q;
    logic [4:0]      rd_q;
    logic            fill;

    logic            big_step;
    logic [4:0]      step;
    logic [XLEN-1:0] work_next;

    // Step size for this edge: the fast build takes four bits at a time
    // while at least four remain, so the tail is always done bit by bit.
    always_comb begin
        big_step = 1'b0;
`ifdef SHIFT_UNIT_FAST_EN
        big_step = (count >= 5'd4);
`endif
        step = big_step ? 5'd4 : 5'd1;
    end

    always_comb begin
        work_next = work;
        case (op_q)
            OP_SLL: work_next = big_step ? {work[XLEN-5:0], 4'b0000}
                                         : {work[XLEN-2:0], 1'b0};
            OP_SRL: work_next = big_step ? {4'b0000, work[XLEN-1:4]}
                                         : {1'b0, work[XLEN-1:1]};
            OP_SRA: work_next = big_step ? {{4{fill}}, work[XLEN-1:4]}
                                         : {fill, work[XLEN-1:1]};
            // Reserved encoding: operand passes through, count still runs
            // so the latency matches a real shift of the same amount.
            default: work_next = work;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            work     <= '0;
            count    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            fill     <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            we_o     <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    we_o   <= 1'b0;
                    if (start_i) begin
                        work   <= operand_i;
                        count  <= shamt_i;
                        op_q   <= op_i;
                        rd_q   <= rd_i;
                        fill   <= (op_i == OP_SRA) ? operand_i[XLEN-1] : 1'b0;
                        busy_o <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (count != 5'd0) begin
                        work  <= work_next;
                        count <= count - step;
                    end else begin
                        result_o <= work;
                        rd_o     <= rd_q;
                        done_o   <= 1'b1;
                        // x0 is hardwired to zero: pulse done but never write
                        we_o     <= (rd_q != 5'd0);
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    we_o   <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    we_o   <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed self-checking bench for shift_unit

module tb_shift_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] operand_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [4:0]  rd_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        we_o;

    int checks = 0;
    int errors = 0;

    shift_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (start_i),
        .op_i      (op_i),
        .operand_i (operand_i),
        .shamt_i   (shamt_i),
        .rd_i      (rd_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .rd_o      (rd_o),
        .we_o      (we_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int sh);
`ifdef SHIFT_UNIT_FAST_EN
        return sh / 4 + sh % 4 + 2;
`else
        return sh + 2;
`endif
    endfunction

    // Drives a request for edge 0; returns at the sample point of cycle 1
    // with start_i dropped and the other inputs scrambled.
    task automatic issue(input logic [1:0] op, input logic [31:0] opnd,
                         input logic [4:0] sh, input logic [4:0] rd);
        @(negedge clk);
        start_i = 1'b1; op_i = op; operand_i = opnd; shamt_i = sh; rd_i = rd;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; op_i = 2'b01; operand_i = 32'hDEAD_BEEF;
        shamt_i = 5'd17; rd_i = 5'd9;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_o && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] opnd,
                       input logic [4:0] sh, input logic [4:0] rd, input logic [31:0] exp);
        int cyc;
        issue(op, opnd, sh, rd);
        wait_done(cyc);
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check({tag, "_lat"}, cyc, exp_lat(int'(sh)));
        check({tag, "_result"}, result_o, exp);
        check({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
        check({tag, "_we"}, {31'd0, we_o}, {31'd0, rd != 5'd0});
        check({tag, "_busy_done"}, {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        check({tag, "_done_drop"}, {31'd0, done_o}, 32'd0);
        check({tag, "_busy_drop"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_result_hold"}, result_o, exp);
    endtask

    initial begin
        int lat;
        int cyc;
        int pulses;

        #12;
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_we", {31'd0, we_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_rd", {27'd0, rd_o}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run("srai_1", 2'b11, 32'hFFFF_FFFE, 5'd1, 5'd6, 32'hFFFF_FFFF);
        run("sra_31", 2'b11, 32'h8000_0000, 5'd31, 5'd7, 32'hFFFF_FFFF);
        run("srl_31", 2'b01, 32'h8000_0000, 5'd31, 5'd8, 32'h0000_0001);
        run("sll_31", 2'b00, 32'h0000_0001, 5'd31, 5'd9, 32'h8000_0000);
        run("sll_0", 2'b00, 32'h1234_5678, 5'd0, 5'd10, 32'h1234_5678);
        run("sra_5", 2'b11, 32'h8000_0000, 5'd5, 5'd11, 32'hFC00_0000);
        run("srl_7", 2'b01, 32'hA5A5_A5A5, 5'd7, 5'd12, 32'h014B_4B4B);
        run("sra_pos", 2'b11, 32'h7000_0000, 5'd6, 5'd13, 32'h01C0_0000);
        run("rsvd_7", 2'b10, 32'hA5A5_A5A5, 5'd7, 5'd14, 32'hA5A5_A5A5);
        run("sra_0", 2'b11, 32'h8000_0001, 5'd0, 5'd15, 32'h8000_0001);

        // Busy rule: extra starts in cycle 2 and in the DONE cycle are dropped.
        lat = exp_lat(4);
        pulses = 0;
        issue(2'b01, 32'hF000_0000, 5'd4, 5'd3);
        for (int c = 1; c <= lat; c++) begin
            if (done_o) begin
                pulses++;
                check("busy_rule_result", result_o, 32'h0F00_0000);
                check("busy_rule_cycle", c, lat);
            end
            start_i = (c == 2 || c == lat);
            op_i = 2'b00; operand_i = 32'h0000_FFFF; shamt_i = 5'd1; rd_i = 5'd21;
            @(negedge clk);
        end
        if (done_o) pulses++;
        check("busy_rule_pulses", pulses, 1);
        check("busy_rule_idle", {31'd0, busy_o}, 32'd0);
        // First edge after DONE accepts: x0 guard op.
        start_i = 1'b1; op_i = 2'b00; operand_i = 32'h0000_0001; shamt_i = 5'd3; rd_i = 5'd0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; operand_i = 32'h5555_5555;
        check("next_start_accepted", {31'd0, busy_o}, 32'd1);
        wait_done(cyc);
        check("x0_done", {31'd0, done_o}, 32'd1);
        check("x0_lat", cyc, exp_lat(3));
        check("x0_result", result_o, 32'h0000_0008);
        check("x0_we", {31'd0, we_o}, 32'd0);
        check("x0_rd", {27'd0, rd_o}, 32'd0);
        @(negedge clk);

        // Reset in cycle 10 of a shamt-20 op: asynchronous drop, no pulse after.
        issue(2'b00, 32'h0000_0003, 5'd20, 5'd4);
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o || we_o || busy_o) pulses++;
        end
        check("rst_no_pulse", pulses, 0);
        run("post_rst_srai", 2'b11, 32'hFFFF_FFF0, 5'd2, 5'd5, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
